seq_cu: RTL and testbench
=========================

SEQ_CU -- requirements
Module: seq_cu

Interface
REQ-001 Parameter NSRC, default 4: number of interrupt sources, legal 1..8.
REQ-002 Parameter STK_CYC, default 2: cycles per stack access, legal 1..4.
REQ-003 Parameter VW, default max(1,clog2(NSRC)): vec_sel width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 Opcode  in  8  instruction opcode, [7:6] class, [5:3] group, [2:0] func.
REQ-007 op_valid  in  1  Opcode is a real instruction this cycle; 0 = bubble.
REQ-008 INT  in  NSRC  interrupt request lines; rising edge requests.
REQ-009 flush  in  1  squash the instruction decoded this cycle.
REQ-010 WB, MR, MW, Jmp  out  1 each  register write-back, memory read, memory write, PC redirect.
REQ-011 Stack_PC, Stack_Flags, StackOp  out  1 each  stack carries PC, stack carries flags, stack direction (0 push, 1 pop).
REQ-012 ALU_Ops  out  3  ALU function, equal to Opcode[2:0] for ALU instructions, else 0.
REQ-013 stall  out  1  fetch/decode must hold Opcode.
REQ-014 int_ack  out  NSRC  one-hot, one-cycle acknowledge.
REQ-015 vec_sel  out  VW  index of the interrupt being serviced.

Function
REQ-016 All outputs registered; a RUN-state decode appears one clock after Opcode is sampled.
REQ-017 RUN decode: ADD/SUB/AND 00_000_xxx -> WB; LDD 00_001 -> WB,MR; STD 00_010 -> MW; MOV 00_100 -> WB; LDM 01_100 and SHL/SHR 01_000_10x -> WB; INC/DEC/NOT 10_000_xxx -> WB.
REQ-018 RUN decode: JZ/JN/JC/JMP 10_011_0xx -> Jmp; CALL 10_110_000 -> MW,Stack_PC,Jmp,StackOp=0; PUSH 10_111_000 -> MW,StackOp=0; POP 10_111_001 -> WB,MR,StackOp=1; IN 10_101_000 -> WB; OUT 10_101_001 and NOP/SETC/CLRC 11_100_xxx and RET 11_110_000 (single cycle: MR,Stack_PC,StackOp=1,Jmp) as listed; any other opcode -> all zero.
REQ-019 op_valid=0 or flush=1 in RUN -> all control outputs 0 next cycle, no state change.
REQ-020 States: RUN, INT_PC, INT_FLG, INT_VEC, RTI_FLG, RTI_PC; 3-bit state register plus 2-bit cycle counter.
REQ-021 INT edge detection: pend[i] set when INT[i]=1 and previous INT[i]=0; cleared by int_ack[i]; a new edge in the ack cycle keeps pend[i]=1.
REQ-022 RUN with pend!=0 and in_service=0 -> INT_PC; lowest index wins; vec_sel latched; Opcode not decoded; interrupt check precedes decode and flush.
REQ-023 INT_PC: MW,Stack_PC,StackOp=0 for STK_CYC cycles -> INT_FLG: MW,Stack_Flags,StackOp=0 for STK_CYC cycles -> INT_VEC: MR,Jmp,int_ack[vec_sel] for 1 cycle -> RUN; in_service set on entry to INT_PC.
REQ-024 RTI 11_110_001 in RUN (valid, not flushed) -> RTI_FLG: MR,Stack_Flags,StackOp=1 for STK_CYC cycles -> RTI_PC: MR,Stack_PC,StackOp=1 for STK_CYC cycles, Jmp on its last cycle -> RUN, in_service cleared.
REQ-025 No nesting: while in_service=1, edges still set pend but no INT_PC entry until RTI completes.
REQ-026 stall=1 in every cycle whose next state is not RUN; stall=0 otherwise.
REQ-027 flush and Opcode ignored in every non-RUN state.
REQ-028 Counter resets to 0 on each state entry; exits at STK_CYC-1; STK_CYC=1 gives single-cycle stack states.

Reset
REQ-029 rst=1 forces immediately: state RUN, counter 0, all outputs 0, pend 0, in_service 0, INT history 0.
REQ-030 rst mid-sequence abandons it; INT held high at release counts as an edge on the first clock.

Verification
REQ-031 Opcode 00_001_000, op_valid=1 -> next cycle WB=1,MR=1, others 0; op_valid=0 -> all 0.
REQ-032 STK_CYC=2, INT[2] pulse in RUN -> stall 5 cycles; MW,Stack_PC 2 cycles; MW,Stack_Flags 2 cycles; Jmp,int_ack=0100,vec_sel=2 for 1 cycle.
REQ-033 INT[3] and INT[1] rise same cycle -> vec_sel=1 serviced; INT[3] serviced only after RTI.
REQ-034 RTI, STK_CYC=2 -> 2 cycles MR,Stack_Flags,StackOp=1; 2 cycles MR,Stack_PC,StackOp=1, Jmp on 4th; stall 1 for 4 cycles.
REQ-035 flush=1 with CALL in RUN -> all outputs 0; flush=1 during INT_FLG -> sequence unaffected.
REQ-036 rst asserted in INT_FLG -> outputs 0 without clock; after release, Opcode 10_111_000 -> MW=1,StackOp=0 next cycle.

Source files
------------

// File: rtl/seq_cu.sv
// Sequencing control unit: registered instruction decode plus the interrupt-entry
// and RTI stack sequences, with rising-edge interrupt capture and fixed priority.
module seq_cu #(
   parameter int NSRC    = 4,
   parameter int STK_CYC = 2,
   parameter int VW      = (NSRC > 1) ? $clog2(NSRC) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      Opcode,
   input  logic            op_valid,
   input  logic [NSRC-1:0] INT,
   input  logic            flush,
   output logic            WB,
   output logic            MR,
   output logic            MW,
   output logic            Jmp,
   output logic            Stack_PC,
   output logic            Stack_Flags,
   output logic            StackOp,
   output logic [2:0]      ALU_Ops,
   output logic            stall,
   output logic [NSRC-1:0] int_ack,
   output logic [VW-1:0]   vec_sel
);

   typedef enum logic [2:0] {
      S_RUN     = 3'd0,
      S_INT_PC  = 3'd1,
      S_INT_FLG = 3'd2,
      S_INT_VEC = 3'd3,
      S_RTI_FLG = 3'd4,
      S_RTI_PC  = 3'd5
   } state_t;

   localparam logic [1:0] LAST   = 2'(STK_CYC - 1);
   localparam logic [7:0] OP_RTI = 8'b11_110_001;

   // Control word layout: {WB, MR, MW, Jmp, Stack_PC, Stack_Flags, StackOp, ALU_Ops[2:0]}
   localparam logic [9:0] C_PUSH_PC  = 10'b0010100000;
   localparam logic [9:0] C_PUSH_FLG = 10'b0010010000;
   localparam logic [9:0] C_VEC      = 10'b0101000000;
   localparam logic [9:0] C_POP_FLG  = 10'b0100011000;
   localparam logic [9:0] C_POP_PC   = 10'b0100101000;
   localparam logic [9:0] C_POP_PC_J = 10'b0101101000;

   state_t          state;
   logic [1:0]      cnt;
   logic [9:0]      ctrl;
   logic [NSRC-1:0] pend;
   logic [NSRC-1:0] int_prev;
   logic            in_service;

   assign {WB, MR, MW, Jmp, Stack_PC, Stack_Flags, StackOp, ALU_Ops} = ctrl;

   function automatic logic [9:0] decode(input logic [7:0] op);
      logic [9:0] c;
      c = '0;
      casez (op)
         8'b00_000_???: c = {7'b1000000, op[2:0]};
         8'b00_001_???: c = 10'b1100000000;
         8'b00_010_???: c = 10'b0010000000;
         8'b00_100_???,
         8'b01_100_???,
         8'b10_101_000: c = 10'b1000000000;
         8'b01_000_10?,
         8'b10_000_???: c = {7'b1000000, op[2:0]};
         8'b10_011_0??: c = 10'b0001000000;
         8'b10_110_000: c = 10'b0011100000;
         8'b10_111_000: c = 10'b0010000000;
         8'b10_111_001: c = 10'b1100001000;
         8'b11_110_000: c = C_POP_PC_J;
         default:       c = '0;
      endcase
      return c;
   endfunction

   // Lowest pending index wins, so scan from the top down.
   function automatic logic [VW-1:0] lowest(input logic [NSRC-1:0] p);
      logic [VW-1:0] idx;
      idx = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (p[i]) idx = VW'(i);
      end
      return idx;
   endfunction

   // Outputs are loaded on the same edge that enters a state/count, so each
   // control word is visible exactly during the cycle it describes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_RUN;
         cnt        <= '0;
         ctrl       <= '0;
         stall      <= 1'b0;
         int_ack    <= '0;
         vec_sel    <= '0;
         pend       <= '0;
         int_prev   <= '0;
         in_service <= 1'b0;
      end else begin
         int_prev <= INT;
         pend     <= (pend & ~int_ack) | (INT & ~int_prev);
         int_ack  <= '0;
         ctrl     <= '0;
         stall    <= 1'b0;
         case (state)
            S_RUN: begin
               if (pend != '0 && !in_service) begin
                  state      <= S_INT_PC;
                  cnt        <= '0;
                  ctrl       <= C_PUSH_PC;
                  stall      <= 1'b1;
                  in_service <= 1'b1;
                  vec_sel    <= lowest(pend);
               end else if (op_valid && !flush) begin
                  if (Opcode == OP_RTI) begin
                     state <= S_RTI_FLG;
                     cnt   <= '0;
                     ctrl  <= C_POP_FLG;
                     stall <= 1'b1;
                  end else begin
                     ctrl <= decode(Opcode);
                  end
               end
            end
            S_INT_PC: begin
               stall <= 1'b1;
               if (cnt == LAST) begin
                  state <= S_INT_FLG;
                  cnt   <= '0;
                  ctrl  <= C_PUSH_FLG;
               end else begin
                  cnt  <= cnt + 2'd1;
                  ctrl <= C_PUSH_PC;
               end
            end
            S_INT_FLG: begin
               stall <= 1'b1;
               if (cnt == LAST) begin
                  state   <= S_INT_VEC;
                  cnt     <= '0;
                  ctrl    <= C_VEC;
                  int_ack <= NSRC'(1) << vec_sel;
               end else begin
                  cnt  <= cnt + 2'd1;
                  ctrl <= C_PUSH_FLG;
               end
            end
            S_INT_VEC: begin
               state <= S_RUN;
               cnt   <= '0;
            end
            S_RTI_FLG: begin
               stall <= 1'b1;
               if (cnt == LAST) begin
                  state <= S_RTI_PC;
                  cnt   <= '0;
                  ctrl  <= (LAST == 2'd0) ? C_POP_PC_J : C_POP_PC;
               end else begin
                  cnt  <= cnt + 2'd1;
                  ctrl <= C_POP_FLG;
               end
            end
            S_RTI_PC: begin
               if (cnt == LAST) begin
                  state      <= S_RUN;
                  cnt        <= '0;
                  in_service <= 1'b0;
               end else begin
                  stall <= 1'b1;
                  cnt   <= cnt + 2'd1;
                  ctrl  <= ((cnt + 2'd1) == LAST) ? C_POP_PC_J : C_POP_PC;
               end
            end
            default: begin
               state <= S_RUN;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_cu.sv
// Directed self-checking bench for seq_cu with default parameters (NSRC=4, STK_CYC=2).
module tb_seq_cu;

   logic       clk;
   logic       rst;
   logic [7:0] Opcode;
   logic       op_valid;
   logic [3:0] INT;
   logic       flush;
   logic       WB, MR, MW, Jmp, Stack_PC, Stack_Flags, StackOp;
   logic [2:0] ALU_Ops;
   logic       stall;
   logic [3:0] int_ack;
   logic [1:0] vec_sel;

   int compared;
   int mismatched;

   // Expected control words: {WB,MR,MW,Jmp,Stack_PC,Stack_Flags,StackOp,ALU_Ops[2:0],stall}
   localparam logic [10:0] E_ZERO    = 11'b0000000000_0;
   localparam logic [10:0] E_LDD     = 11'b1100000000_0;
   localparam logic [10:0] E_ADD5    = 11'b1000000101_0;
   localparam logic [10:0] E_STD     = 11'b0010000000_0;
   localparam logic [10:0] E_SHL     = 11'b1000000100_0;
   localparam logic [10:0] E_JZ      = 11'b0001000000_0;
   localparam logic [10:0] E_POP     = 11'b1100001000_0;
   localparam logic [10:0] E_RET     = 11'b0101101000_0;
   localparam logic [10:0] E_CALL    = 11'b0011100000_0;
   localparam logic [10:0] E_PUSH    = 11'b0010000000_0;
   localparam logic [10:0] E_IPC     = 11'b0010100000_1;
   localparam logic [10:0] E_IFLG    = 11'b0010010000_1;
   localparam logic [10:0] E_IVEC    = 11'b0101000000_1;
   localparam logic [10:0] E_RFLG    = 11'b0100011000_1;
   localparam logic [10:0] E_RPC     = 11'b0100101000_1;
   localparam logic [10:0] E_RPC_J   = 11'b0101101000_1;

   localparam logic [7:0] OP_NOP  = 8'b11_100_000;
   localparam logic [7:0] OP_CALL = 8'b10_110_000;
   localparam logic [7:0] OP_RTI  = 8'b11_110_001;
   localparam logic [7:0] OP_PUSH = 8'b10_111_000;

   seq_cu dut (
      .clk         (clk),
      .rst         (rst),
      .Opcode      (Opcode),
      .op_valid    (op_valid),
      .INT         (INT),
      .flush       (flush),
      .WB          (WB),
      .MR          (MR),
      .MW          (MW),
      .Jmp         (Jmp),
      .Stack_PC    (Stack_PC),
      .Stack_Flags (Stack_Flags),
      .StackOp     (StackOp),
      .ALU_Ops     (ALU_Ops),
      .stall       (stall),
      .int_ack     (int_ack),
      .vec_sel     (vec_sel)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [10:0] ctl();
      return {WB, MR, MW, Jmp, Stack_PC, Stack_Flags, StackOp, ALU_Ops, stall};
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] op, input logic v, input logic f,
                                input logic [3:0] irq);
      Opcode   = op;
      op_valid = v;
      flush    = f;
      INT      = irq;
      @(posedge clk);
      #1;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      Opcode     = 8'h00;
      op_valid   = 1'b0;
      flush      = 1'b0;
      INT        = 4'b0000;
      rst        = 1'b0;
      #1 rst = 1'b1;
      #1;
      checkOutput("reset_ctl", 16'(ctl()), 16'(E_ZERO));
      checkOutput("reset_ack", 16'(int_ack), 16'h0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Plain decode
      applyStimulus(8'b00_001_000, 1'b1, 1'b0, 4'b0000);
      checkOutput("ldd", 16'(ctl()), 16'(E_LDD));
      applyStimulus(8'b00_001_000, 1'b0, 1'b0, 4'b0000);
      checkOutput("bubble", 16'(ctl()), 16'(E_ZERO));
      applyStimulus(8'b00_000_101, 1'b1, 1'b0, 4'b0000);
      checkOutput("add_alu", 16'(ctl()), 16'(E_ADD5));
      applyStimulus(8'b00_010_000, 1'b1, 1'b0, 4'b0000);
      checkOutput("std", 16'(ctl()), 16'(E_STD));
      applyStimulus(8'b01_000_100, 1'b1, 1'b0, 4'b0000);
      checkOutput("shl", 16'(ctl()), 16'(E_SHL));
      applyStimulus(8'b01_000_110, 1'b1, 1'b0, 4'b0000);
      checkOutput("illegal", 16'(ctl()), 16'(E_ZERO));
      applyStimulus(8'b10_011_010, 1'b1, 1'b0, 4'b0000);
      checkOutput("jz", 16'(ctl()), 16'(E_JZ));
      applyStimulus(8'b10_111_001, 1'b1, 1'b0, 4'b0000);
      checkOutput("pop", 16'(ctl()), 16'(E_POP));
      applyStimulus(8'b11_110_000, 1'b1, 1'b0, 4'b0000);
      checkOutput("ret", 16'(ctl()), 16'(E_RET));
      applyStimulus(OP_CALL, 1'b1, 1'b1, 4'b0000);
      checkOutput("call_flushed", 16'(ctl()), 16'(E_ZERO));
      applyStimulus(OP_CALL, 1'b1, 1'b0, 4'b0000);
      checkOutput("call", 16'(ctl()), 16'(E_CALL));

      // Single interrupt on INT[2], flush during INT_FLG must not disturb it
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0100);
      checkOutput("irq_capture", 16'(ctl()), 16'(E_ZERO));
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0000);
      checkOutput("ipc0", 16'(ctl()), 16'(E_IPC));
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0000);
      checkOutput("ipc1", 16'(ctl()), 16'(E_IPC));
      applyStimulus(OP_CALL, 1'b1, 1'b1, 4'b0000);
      checkOutput("iflg0_flush", 16'(ctl()), 16'(E_IFLG));
      applyStimulus(OP_CALL, 1'b1, 1'b1, 4'b0000);
      checkOutput("iflg1_flush", 16'(ctl()), 16'(E_IFLG));
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0000);
      checkOutput("ivec", 16'(ctl()), 16'(E_IVEC));
      checkOutput("ivec_ack", 16'(int_ack), 16'b0100);
      checkOutput("ivec_sel", 16'(vec_sel), 16'd2);
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0000);
      checkOutput("back_run", 16'(ctl()), 16'(E_ZERO));
      checkOutput("ack_clear", 16'(int_ack), 16'h0);

      // RTI sequence
      applyStimulus(OP_RTI, 1'b1, 1'b0, 4'b0000);
      checkOutput("rflg0", 16'(ctl()), 16'(E_RFLG));
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0000);
      checkOutput("rflg1", 16'(ctl()), 16'(E_RFLG));
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0000);
      checkOutput("rpc0", 16'(ctl()), 16'(E_RPC));
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0000);
      checkOutput("rpc1_jmp", 16'(ctl()), 16'(E_RPC_J));
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0000);
      checkOutput("rti_done", 16'(ctl()), 16'(E_ZERO));

      // Simultaneous INT[3] and INT[1]: 1 first, 3 only after RTI
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b1010);
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0000);
      checkOutput("prio_ipc", 16'(ctl()), 16'(E_IPC));
      checkOutput("prio_sel", 16'(vec_sel), 16'd1);
      for (int i = 0; i < 3; i++) applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0000);
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0000);
      checkOutput("prio_ack", 16'(int_ack), 16'b0010);
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0000);
      applyStimulus(8'b00_100_000, 1'b1, 1'b0, 4'b0000);
      checkOutput("no_nesting", 16'(ctl()), 16'(11'b1000000000_0));
      applyStimulus(OP_RTI, 1'b1, 1'b0, 4'b0000);
      for (int i = 0; i < 3; i++) applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0000);
      checkOutput("rti2_jmp", 16'(ctl()), 16'(E_RPC_J));
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0000);
      checkOutput("rti2_done", 16'(ctl()), 16'(E_ZERO));
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0000);
      checkOutput("irq3_ipc", 16'(ctl()), 16'(E_IPC));
      checkOutput("irq3_sel", 16'(vec_sel), 16'd3);
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0000);
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0000);
      checkOutput("irq3_iflg", 16'(ctl()), 16'(E_IFLG));

      // Asynchronous reset in INT_FLG
      #1 rst = 1'b1;
      #1;
      checkOutput("async_rst", 16'(ctl()), 16'(E_ZERO));
      @(posedge clk);
      #1 rst = 1'b0;
      applyStimulus(OP_PUSH, 1'b1, 1'b0, 4'b0000);
      checkOutput("push_after_rst", 16'(ctl()), 16'(E_PUSH));

      // INT held high across reset release counts as an edge
      INT = 4'b0001;
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0001);
      checkOutput("held_capture", 16'(ctl()), 16'(E_ZERO));
      applyStimulus(OP_NOP, 1'b1, 1'b0, 4'b0001);
      checkOutput("held_ipc", 16'(ctl()), 16'(E_IPC));
      checkOutput("held_sel", 16'(vec_sel), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
